// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
// Also used by the RX side through the hold timer.
package uart_tx_pkg;

  localparam int TIMER_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2,
    GAP     = 2'd3
  } state_t;

  // Width of a byte index for an n-byte word, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_hold_timer.sv
// Free-running hold counter with synchronous clear.
// The owner clears it on every state change and while in reset.
module uart_hold_timer
  import uart_tx_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_clear,
  output logic [TIMER_W-1:0] o_count
);

  logic [TIMER_W-1:0] r_count;

  // Count up each cycle, restart from zero on clear.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/uart_tx_word_sequencer.sv
// Serialises a DATA_BYTES-wide word into paced single-byte UART transfers,
// with selectable byte order and optional tx_done handshake.
module uart_tx_word_sequencer
  import uart_tx_pkg::*;
#(
  parameter int DATA_BYTES       = 2,
  parameter int CAPTURE_DELAY    = 100,
  parameter int INTER_BYTE_DELAY = 1000000,
  parameter int MSB_FIRST        = 0,
  parameter int USE_TX_DONE      = 0
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic                             i_start,
  input  logic [8*DATA_BYTES-1:0]          i_data_in,
  input  logic                             i_tx_done,
  output logic [7:0]                       o_tx_data,
  output logic                             o_tx_start,
  output logic                             o_busy,
  output logic [idx_w(DATA_BYTES)-1:0]     o_byte_index,
  output logic                             o_frame_done
);

  localparam int IW = idx_w(DATA_BYTES);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [8*DATA_BYTES-1:0] r_data_reg;
  logic [8*DATA_BYTES-1:0] w_data_nxt;
  logic [IW-1:0]           r_byte_index;
  logic [IW-1:0]           w_idx_nxt;
  logic                    r_done_seen;
  logic                    r_tx_start;
  logic                    r_busy;
  logic                    r_frame_done;
  logic [7:0]              r_tx_data;
  logic [7:0]              w_byte_nxt;
  logic [TIMER_W-1:0]      w_count;
  logic                    w_timer_clear;
  logic                    w_gap_exit;
  logic                    w_last;
  int                      w_k;

  uart_hold_timer u_timer (
    .i_clk   (i_clock),
    .i_clear (w_timer_clear),
    .o_count (w_count)
  );

  assign w_last        = (r_byte_index == IW'(DATA_BYTES - 1));
  assign w_timer_clear = (w_state_nxt != r_state) || !i_reset_n;

  // A tx_done arriving in the exit cycle itself counts, so it is ORed in live.
  assign w_gap_exit = (r_state == GAP)
                   && (w_count >= TIMER_W'(INTER_BYTE_DELAY))
                   && ((USE_TX_DONE == 0) || r_done_seen || i_tx_done);

  // Next-state, captured word, byte index and the byte that index selects.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data_reg;
    w_idx_nxt   = r_byte_index;
    case (r_state)
      IDLE: begin
        w_idx_nxt = '0;
        if (i_start) begin
          w_state_nxt = CAPTURE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CAPTURE: begin
        if (w_count >= TIMER_W'(CAPTURE_DELAY)) begin
          w_state_nxt = SEND;
          w_data_nxt  = i_data_in;
        end else begin
          w_state_nxt = CAPTURE;
        end
      end
      SEND: begin
        w_state_nxt = GAP;
      end
      GAP: begin
        if (w_gap_exit && w_last) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else if (w_gap_exit) begin
          w_state_nxt = SEND;
          w_idx_nxt   = r_byte_index + IW'(1);
        end else begin
          w_state_nxt = GAP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
    if (MSB_FIRST != 0) begin
      w_k = DATA_BYTES - 1 - int'(w_idx_nxt);
    end else begin
      w_k = int'(w_idx_nxt);
    end
    w_byte_nxt = w_data_nxt[8*w_k +: 8];
  end

  // State, datapath and registered outputs; reset is synchronous.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_data_reg   <= '0;
      r_byte_index <= '0;
      r_done_seen  <= 1'b0;
      r_tx_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_tx_data    <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_data_reg   <= w_data_nxt;
      r_byte_index <= w_idx_nxt;
      r_tx_start   <= (w_state_nxt == SEND);
      r_busy       <= (w_state_nxt != IDLE);
      r_frame_done <= w_gap_exit && w_last;
      r_tx_data    <= w_byte_nxt;
      case (r_state)
        SEND:    r_done_seen <= i_tx_done;
        GAP:     r_done_seen <= r_done_seen | i_tx_done;
        default: r_done_seen <= 1'b0;
      endcase
    end
  end

  assign o_tx_data    = r_tx_data;
  assign o_tx_start   = r_tx_start;
  assign o_busy       = r_busy;
  assign o_byte_index = r_byte_index;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_word_sequencer.sv
// Directed bench for uart_tx_word_sequencer: four instances cover byte order,
// tx_done handshake and the single-byte frame with shared stimulus.
module tb_uart_tx_word_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] data_in;
  logic [7:0]  data_one;
  logic        tx_done;

  logic [7:0] b_data, m_data, d_data, o_data;
  logic       b_start, m_start, d_start, o_start;
  logic       b_busy, m_busy, d_busy, o_busy;
  logic [1:0] b_idx, m_idx, d_idx;
  logic [0:0] o_idx;
  logic       b_fd, m_fd, d_fd, o_fd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_word_sequencer #(.DATA_BYTES(3), .CAPTURE_DELAY(2), .INTER_BYTE_DELAY(4),
                           .MSB_FIRST(0), .USE_TX_DONE(0)) u_base (
    .i_clock(clk), .i_reset_n(reset_n), .i_start(start), .i_data_in(data_in),
    .i_tx_done(tx_done), .o_tx_data(b_data), .o_tx_start(b_start), .o_busy(b_busy),
    .o_byte_index(b_idx), .o_frame_done(b_fd));

  uart_tx_word_sequencer #(.DATA_BYTES(3), .CAPTURE_DELAY(2), .INTER_BYTE_DELAY(4),
                           .MSB_FIRST(1), .USE_TX_DONE(0)) u_msb (
    .i_clock(clk), .i_reset_n(reset_n), .i_start(start), .i_data_in(data_in),
    .i_tx_done(tx_done), .o_tx_data(m_data), .o_tx_start(m_start), .o_busy(m_busy),
    .o_byte_index(m_idx), .o_frame_done(m_fd));

  uart_tx_word_sequencer #(.DATA_BYTES(3), .CAPTURE_DELAY(2), .INTER_BYTE_DELAY(4),
                           .MSB_FIRST(0), .USE_TX_DONE(1)) u_done (
    .i_clock(clk), .i_reset_n(reset_n), .i_start(start), .i_data_in(data_in),
    .i_tx_done(tx_done), .o_tx_data(d_data), .o_tx_start(d_start), .o_busy(d_busy),
    .o_byte_index(d_idx), .o_frame_done(d_fd));

  uart_tx_word_sequencer #(.DATA_BYTES(1), .CAPTURE_DELAY(2), .INTER_BYTE_DELAY(4),
                           .MSB_FIRST(0), .USE_TX_DONE(0)) u_one (
    .i_clock(clk), .i_reset_n(reset_n), .i_start(start), .i_data_in(data_one),
    .i_tx_done(tx_done), .o_tx_data(o_data), .o_tx_start(o_start), .o_busy(o_busy),
    .o_byte_index(o_idx), .o_frame_done(o_fd));

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Two reset edges, then return just after a rising edge, ready to drive c0.
  task automatic apply_reset;
    reset_n  = 1'b0;
    start    = 1'b0;
    tx_done  = 1'b0;
    data_in  = 24'hA1B2C3;
    data_one = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset;
    @(negedge clk);
    total++;
    if ({b_data, b_start, b_busy, b_fd, b_idx} !== {8'h00, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL reset_outputs got data=%h start=%b busy=%b fd=%b idx=%0d want 00/0/0/0/0",
               b_data, b_start, b_busy, b_fd, b_idx);
    end
    next_cycle;
  endtask

  // Full three-byte frame with timing of every output; msb selects instance.
  task automatic test_byte_order(input bit msb);
    logic [23:0] word;
    logic [7:0]  exp_byte;
    logic        s, bz, fd;
    logic [7:0]  dat;
    int          k;
    word = 24'hA1B2C3;
    apply_reset;
    for (int c = 0; c <= 23; c++) begin
      start = (c == 0);
      @(negedge clk);
      s   = msb ? m_start : b_start;
      bz  = msb ? m_busy  : b_busy;
      fd  = msb ? m_fd    : b_fd;
      dat = msb ? m_data  : b_data;
      total++;
      if (s !== (c == 4 || c == 10 || c == 16)) begin
        bad++;
        $display("FAIL order%0d_tx_start c%0d got=%b", msb, c, s);
      end
      total++;
      if (bz !== (c >= 1 && c <= 21)) begin
        bad++;
        $display("FAIL order%0d_busy c%0d got=%b", msb, c, bz);
      end
      total++;
      if (fd !== (c == 22)) begin
        bad++;
        $display("FAIL order%0d_frame_done c%0d got=%b", msb, c, fd);
      end
      if (c == 4 || c == 10 || c == 16) begin
        k = (c - 4) / 6;
        if (msb) k = 2 - k;
        exp_byte = word[8*k +: 8];
        total++;
        if (dat !== exp_byte) begin
          bad++;
          $display("FAIL order%0d_tx_data c%0d got=%h want=%h", msb, c, dat, exp_byte);
        end
      end
      next_cycle;
    end
  endtask

  // Data change in c3 is captured; change in c4 is not.
  task automatic test_capture(input int change_cycle);
    logic [23:0] exp_word;
    logic [7:0]  exp_byte;
    exp_word = (change_cycle == 3) ? 24'h0F0E0D : 24'hA1B2C3;
    apply_reset;
    for (int c = 0; c <= 17; c++) begin
      start = (c == 0);
      if (c == change_cycle) data_in = 24'h0F0E0D;
      @(negedge clk);
      if (c == 4 || c == 10 || c == 16) begin
        exp_byte = exp_word[8*((c - 4) / 6) +: 8];
        total++;
        if (b_start !== 1'b1 || b_data !== exp_byte) begin
          bad++;
          $display("FAIL capture_c%0d byte c%0d got start=%b data=%h want 1/%h",
                   change_cycle, c, b_start, b_data, exp_byte);
        end
      end
      next_cycle;
    end
  endtask

  // Handshake mode: the second launch waits for tx_done when it comes late.
  task automatic test_tx_done(input int done_cycle, input int second_start);
    apply_reset;
    for (int c = 0; c <= second_start + 1; c++) begin
      start   = (c == 0);
      tx_done = (c == done_cycle);
      @(negedge clk);
      total++;
      if (d_start !== (c == 4 || c == second_start)) begin
        bad++;
        $display("FAIL txdone_%0d_tx_start c%0d got=%b", done_cycle, c, d_start);
      end
      if (c == second_start) begin
        total++;
        if (d_data !== 8'hB2 || d_idx !== 2'd1) begin
          bad++;
          $display("FAIL txdone_%0d_second_byte got data=%h idx=%0d want B2/1",
                   done_cycle, d_data, d_idx);
        end
      end
      next_cycle;
    end
    tx_done = 1'b0;
  endtask

  // Reset in c11 aborts the frame without further launches or frame_done.
  task automatic test_reset_mid_frame;
    apply_reset;
    for (int c = 0; c <= 30; c++) begin
      start   = (c == 0);
      reset_n = (c != 11);
      @(negedge clk);
      if (c == 12) begin
        total++;
        if ({b_start, b_busy, b_fd, b_data} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
          bad++;
          $display("FAIL midreset_c12 got start=%b busy=%b fd=%b data=%h want 0/0/0/00",
                   b_start, b_busy, b_fd, b_data);
        end
      end
      if (c > 12) begin
        total++;
        if (b_start !== 1'b0 || b_fd !== 1'b0) begin
          bad++;
          $display("FAIL midreset_quiet c%0d got start=%b fd=%b", c, b_start, b_fd);
        end
      end
      next_cycle;
    end
  endtask

  // Start held high: frame_done in c22 and the next frame launches in c26.
  task automatic test_back_to_back;
    apply_reset;
    for (int c = 0; c <= 27; c++) begin
      start = 1'b1;
      @(negedge clk);
      total++;
      if (b_start !== (c == 4 || c == 10 || c == 16 || c == 26)) begin
        bad++;
        $display("FAIL b2b_tx_start c%0d got=%b", c, b_start);
      end
      total++;
      if (b_fd !== (c == 22) || b_busy !== (c != 0 && c != 22)) begin
        bad++;
        $display("FAIL b2b_fd_busy c%0d got fd=%b busy=%b", c, b_fd, b_busy);
      end
      next_cycle;
    end
    start = 1'b0;
  endtask

  task automatic test_single_byte;
    apply_reset;
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0);
      @(negedge clk);
      total++;
      if (o_start !== (c == 4) || o_fd !== (c == 10) || o_idx !== 1'b0) begin
        bad++;
        $display("FAIL single_ctrl c%0d got start=%b fd=%b idx=%0d", c, o_start, o_fd, o_idx);
      end
      if (c == 4) begin
        total++;
        if (o_data !== 8'h5A) begin
          bad++;
          $display("FAIL single_data got=%h want=5a", o_data);
        end
      end
      next_cycle;
    end
  endtask

  initial begin
    test_reset;
    test_byte_order(1'b0);
    test_byte_order(1'b1);
    test_capture(3);
    test_capture(4);
    test_tx_done(12, 13);
    test_tx_done(5, 10);
    test_reset_mid_frame;
    test_back_to_back;
    test_single_byte;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
